// File: rtl/hub75_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// hub75_scan_ctrl_if
//
// Groups the two external buses of the HUB75 scan controller:
//   - frame-buffer read port: fb_rd_en / fb_addr out, fb_rdata back one
//     cycle after the strobe ({R0,G0,B0,R1,G1,B1}, each BITS wide)
//   - panel connector pins: row address A..D, serial colour R0..B1,
//     SCLK, LAT, oe_n
//
// Modports:
//   master - the scan controller (drives strobe, address and panel pins)
//   slave  - frame buffer / panel side (drives fb_rdata, observes the rest)
//
// Handshake: there is no back-pressure. A read issued with fb_rd_en=1 in
// cycle n is always answered by fb_rdata valid in cycle n+1; the controller
// never waits on the frame buffer.
// ---------------------------------------------------------------------------
interface hub75_scan_ctrl_if #(
    parameter int BITS = 4
);
    logic                fb_rd_en;
    logic [9:0]          fb_addr;
    logic [6*BITS-1:0]   fb_rdata;

    logic                A;
    logic                B;
    logic                C;
    logic                D;
    logic                R0;
    logic                G0;
    logic                B0;
    logic                R1;
    logic                G1;
    logic                B1;
    logic                SCLK;
    logic                LAT;
    logic                oe_n;

    modport master (
        output fb_rd_en, fb_addr,
        input  fb_rdata,
        output A, B, C, D,
        output R0, G0, B0, R1, G1, B1,
        output SCLK, LAT, oe_n
    );

    modport slave (
        input  fb_rd_en, fb_addr,
        output fb_rdata,
        input  A, B, C, D,
        input  R0, G0, B0, R1, G1, B1,
        input  SCLK, LAT, oe_n
    );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// ---------------------------------------------------------------------------
// hub75_scan_ctrl
//
// Scan controller for a 64x32, 1/16-scan HUB75 panel. For each of the 16
// rows and each of the BITS bit planes it reads one row of the frame buffer,
// shifts it into the panel, latches it and lights it for BASE_TIME<<plane
// cycles (binary-coded modulation). Both half-panels are driven in parallel:
// R0/G0/B0 carry row r, R1/G1/B1 carry row r+16.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   en         run enable; checked in IDLE and at the end of every DISPLAY
//   bus        hub75_scan_ctrl_if.master: frame-buffer read port + panel pins
//   busy       high whenever the FSM is not in IDLE
//   frame_done one-cycle pulse after the last lit cycle of row 15 / last plane
//   dbg_state  current FSM state (state_t encoding)
//
// Every output is a flop. Output next-values are derived from the FSM's
// next state, so each registered output lines up with the state it belongs
// to. COLS must not exceed 64 (fb_addr carries a 6-bit column).
// ---------------------------------------------------------------------------
module hub75_scan_ctrl #(
    parameter int BITS      = 4,
    parameter int BASE_TIME = 8,
    parameter int COLS      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    hub75_scan_ctrl_if.master    bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic [2:0]           dbg_state
);

    localparam int PW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int TW = $clog2(2 * COLS + 2);
    // Sized for the longest plane so BITS=8 cannot overflow.
    localparam int DW = $clog2((BASE_TIME << (BITS - 1)) + 1);

    localparam logic [TW-1:0] SHIFT_LAST = TW'(2 * COLS + 1);
    localparam logic [TW-1:0] RD_END     = TW'(2 * COLS);
    localparam logic [TW-1:0] FIRST_RISE = TW'(3);
    localparam logic [PW-1:0] PLANE_LAST = PW'(BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_BLANK   = 3'd2,
        S_LATCH   = 3'd3,
        S_DISPLAY = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   shift_t_q, shift_t_d;
    logic [DW-1:0]   disp_t_q, disp_t_d;
    logic [3:0]      row_q, row_d;
    logic [PW-1:0]   plane_q, plane_d;

    logic            fb_rd_en_q, fb_rd_en_d;
    logic [9:0]      fb_addr_q, fb_addr_d;
    logic [3:0]      row_addr_q, row_addr_d;
    logic [5:0]      rgb_q, rgb_d;
    logic            sclk_q, sclk_d;
    logic            lat_q, lat_d;
    logic            oe_n_q, oe_n_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;

    logic [DW-1:0]   disp_last;
    logic [BITS-1:0] r0_w, g0_w, b0_w, r1_w, g1_w, b1_w;

    assign disp_last = (DW'(BASE_TIME) << plane_q) - DW'(1);

    assign r0_w = bus.fb_rdata[6*BITS-1 -: BITS];
    assign g0_w = bus.fb_rdata[5*BITS-1 -: BITS];
    assign b0_w = bus.fb_rdata[4*BITS-1 -: BITS];
    assign r1_w = bus.fb_rdata[3*BITS-1 -: BITS];
    assign g1_w = bus.fb_rdata[2*BITS-1 -: BITS];
    assign b1_w = bus.fb_rdata[BITS-1 -: BITS];

    always_comb begin
        state_d      = state_q;
        shift_t_d    = shift_t_q;
        disp_t_d     = disp_t_q;
        row_d        = row_q;
        plane_d      = plane_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d   = S_SHIFT;
                    shift_t_d = '0;
                end
            end
            S_SHIFT: begin
                if (shift_t_q == SHIFT_LAST) begin
                    state_d = S_BLANK;
                end else begin
                    shift_t_d = shift_t_q + TW'(1);
                end
            end
            S_BLANK: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                state_d  = S_DISPLAY;
                disp_t_d = '0;
            end
            S_DISPLAY: begin
                if (disp_t_q == disp_last) begin
                    frame_done_d = (row_q == 4'd15) && (plane_q == PLANE_LAST);
                    if (plane_q == PLANE_LAST) begin
                        plane_d = '0;
                        row_d   = row_q + 4'd1;
                    end else begin
                        plane_d = plane_q + PW'(1);
                    end
                    shift_t_d = '0;
                    // en only matters here, so a row-plane is never cut short.
                    if (en) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                        row_d   = '0;
                        plane_d = '0;
                    end
                end else begin
                    disp_t_d = disp_t_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Even SHIFT cycles issue reads; column c is read at t=2c.
        fb_rd_en_d = (state_d == S_SHIFT) && !shift_t_d[0] && (shift_t_d < RD_END);
        fb_addr_d  = fb_rd_en_d ? {row_d, 6'(shift_t_d >> 1)} : fb_addr_q;

        // Rising SCLK on odd cycles from t=3: data loaded at t=2c+2 is
        // clocked in at t=2c+3.
        sclk_d = (state_d == S_SHIFT) && shift_t_d[0] && (shift_t_d >= FIRST_RISE);

        lat_d  = (state_d == S_LATCH);
        oe_n_d = (state_d != S_DISPLAY);
        busy_d = (state_d != S_IDLE);

        // Row pins move only while blanked, so the lit row never glitches.
        row_addr_d = row_addr_q;
        if (state_d == S_BLANK) begin
            row_addr_d = row_d;
        end else if (state_d == S_IDLE) begin
            row_addr_d = '0;
        end

        // Read data is valid on odd SHIFT cycles, one cycle after the strobe.
        rgb_d = rgb_q;
        if ((state_q == S_SHIFT) && shift_t_q[0] && (shift_t_q < RD_END)) begin
            rgb_d = {r0_w[plane_q], g0_w[plane_q], b0_w[plane_q],
                     r1_w[plane_q], g1_w[plane_q], b1_w[plane_q]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            shift_t_q    <= '0;
            disp_t_q     <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            fb_rd_en_q   <= 1'b0;
            fb_addr_q    <= '0;
            row_addr_q   <= '0;
            rgb_q        <= '0;
            sclk_q       <= 1'b0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_t_q    <= shift_t_d;
            disp_t_q     <= disp_t_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            fb_rd_en_q   <= fb_rd_en_d;
            fb_addr_q    <= fb_addr_d;
            row_addr_q   <= row_addr_d;
            rgb_q        <= rgb_d;
            sclk_q       <= sclk_d;
            lat_q        <= lat_d;
            oe_n_q       <= oe_n_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.fb_rd_en = fb_rd_en_q;
    assign bus.fb_addr  = fb_addr_q;
    assign {bus.D, bus.C, bus.B, bus.A} = row_addr_q;
    assign {bus.R0, bus.G0, bus.B0, bus.R1, bus.G1, bus.B1} = rgb_q;
    assign bus.SCLK     = sclk_q;
    assign bus.LAT      = lat_q;
    assign bus.oe_n     = oe_n_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hub75_scan_ctrl
//
// Bench for hub75_scan_ctrl at default parameters. A random picture is held
// as pix[row 0..31][col][channel]; the frame-buffer responder packs it into
// {R0,G0,B0,R1,G1,B1} words with one cycle of latency and drives random
// junk when no read is pending. Each run session plans the row-plane
// sequence up front and queues the expected reads, shifted colour bits,
// latch rows and lit-run lengths; a negedge monitor pops and compares them
// as the panel pins show them.
// ---------------------------------------------------------------------------
module tb_hub75_scan_ctrl;

    localparam int BITS         = 4;
    localparam int BASE_TIME    = 8;
    localparam int COLS         = 64;
    localparam int LAT_GAP      = 2 * COLS + 3;   // first SHIFT cycle -> LAT cycle
    localparam int FRAME_CYCLES = 10368;

    logic       clk;
    logic       rst;
    logic       en;
    logic       busy;
    logic       frame_done;
    logic [2:0] dbg_state;

    hub75_scan_ctrl_if #(.BITS(BITS)) bus ();

    hub75_scan_ctrl #(
        .BITS      (BITS),
        .BASE_TIME (BASE_TIME),
        .COLS      (COLS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- picture + frame buffer ----------------
    logic [BITS-1:0] pix [32][COLS][3];

    function automatic logic [6*BITS-1:0] ram_word(input logic [9:0] a);
        int r;
        int c;
        r = int'(a[9:6]);
        c = int'(a[5:0]);
        return {pix[r][c][0], pix[r][c][1], pix[r][c][2],
                pix[r+16][c][0], pix[r+16][c][1], pix[r+16][c][2]};
    endfunction

    function automatic logic [5:0] pin_bits(input int r, input int c, input int p);
        return {pix[r][c][0][p], pix[r][c][1][p], pix[r][c][2][p],
                pix[r+16][c][0][p], pix[r+16][c][1][p], pix[r+16][c][2][p]};
    endfunction

    always @(posedge clk) begin
        if (bus.fb_rd_en) bus.fb_rdata <= ram_word(bus.fb_addr);
        else              bus.fb_rdata <= (6*BITS)'($urandom);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_rd_q[$];
    logic [5:0] exp_bit_q[$];
    logic [3:0] exp_lat_q[$];
    int         exp_run_q[$];

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, expv, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Row-planes run in order: planes 0..BITS-1 of row 0, then row 1, ...
    task automatic plan_session(input int n);
        int row;
        int plane;
        logic [3:0] r4;
        logic [5:0] c6;
        row   = 0;
        plane = 0;
        for (int k = 0; k < n; k++) begin
            r4 = row[3:0];
            for (int c = 0; c < COLS; c++) begin
                c6 = c[5:0];
                exp_rd_q.push_back({r4, c6});
                exp_bit_q.push_back(pin_bits(row, c, plane));
            end
            exp_lat_q.push_back(r4);
            exp_run_q.push_back(BASE_TIME << plane);
            plane++;
            if (plane == BITS) begin
                plane = 0;
                row   = (row + 1) % 16;
            end
        end
    endtask

    // ---------------- monitor ----------------
    int         runs_done   = 0;
    int         fd_cnt      = 0;
    int         fd_ref      = 0;
    int         shift_start = 0;
    int         rd_cnt      = 0;
    int         sclk_cnt    = 0;
    int         run_len     = 0;
    logic       busy_p      = 1'b0;
    logic       oe_p        = 1'b1;
    logic       sclk_p      = 1'b0;
    logic [3:0] lat_row     = '0;

    always @(negedge clk) begin : monitor
        logic [9:0] ea;
        logic [5:0] eb;
        logic [3:0] el;
        int         er;
        if (!rst) begin
            busy_p  = 1'b0;
            oe_p    = 1'b1;
            sclk_p  = 1'b0;
            run_len = 0;
        end else begin
            if ((busy && !busy_p) || (bus.oe_n && !oe_p)) begin
                shift_start = cyc;
                rd_cnt      = 0;
                sclk_cnt    = 0;
            end
            if (busy && !busy_p) fd_ref = cyc;

            if (bus.fb_rd_en) begin
                rd_cnt++;
                if (exp_rd_q.size() == 0) begin
                    fail_now("unexpected_fb_read");
                end else begin
                    ea = exp_rd_q.pop_front();
                    check("fb_addr", int'(bus.fb_addr), int'(ea));
                end
            end

            if (bus.SCLK && !sclk_p) begin
                sclk_cnt++;
                if (exp_bit_q.size() == 0) begin
                    fail_now("unexpected_sclk_rise");
                end else begin
                    eb = exp_bit_q.pop_front();
                    check("colour_bits",
                          int'({bus.R0, bus.G0, bus.B0, bus.R1, bus.G1, bus.B1}), int'(eb));
                end
            end

            if (bus.LAT) begin
                check("lat_while_blank", int'(bus.oe_n), 1);
                check("lat_gap", cyc - shift_start, LAT_GAP);
                check("reads_per_rowplane", rd_cnt, COLS);
                check("sclk_per_rowplane", sclk_cnt, COLS);
                if (exp_lat_q.size() == 0) begin
                    fail_now("unexpected_lat");
                end else begin
                    el = exp_lat_q.pop_front();
                    check("lat_row", int'({bus.D, bus.C, bus.B, bus.A}), int'(el));
                end
                lat_row = {bus.D, bus.C, bus.B, bus.A};
            end

            if (!bus.oe_n) begin
                run_len++;
                check("row_stable_lit", int'({bus.D, bus.C, bus.B, bus.A}), int'(lat_row));
            end

            if (bus.oe_n && !oe_p) begin
                if (exp_run_q.size() == 0) begin
                    fail_now("unexpected_lit_run");
                end else begin
                    er = exp_run_q.pop_front();
                    check("lit_run_len", run_len, er);
                end
                run_len = 0;
                runs_done++;
            end

            if (frame_done) begin
                check("frame_period", cyc - fd_ref, FRAME_CYCLES);
                fd_ref = cyc;
                fd_cnt++;
            end

            busy_p = busy;
            oe_p   = bus.oe_n;
            sclk_p = bus.SCLK;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_runs(input int target);
        int k;
        k = 0;
        while (runs_done < target && k < 30000) begin
            @(negedge clk);
            k++;
        end
        if (runs_done < target) fail_now("wait_runs_timeout");
    endtask

    task automatic finish_session();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (busy) fail_now("wait_idle_timeout");
        @(negedge clk);
        check("rd_q_drained", exp_rd_q.size(), 0);
        check("bit_q_drained", exp_bit_q.size(), 0);
        check("lat_q_drained", exp_lat_q.size(), 0);
        check("run_q_drained", exp_run_q.size(), 0);
        check("idle_oe_n", int'(bus.oe_n), 1);
        check("idle_busy", int'(busy), 0);
    endtask

    // Runs n row-planes: en is dropped somewhere inside the SHIFT of the
    // last one, which must still complete its full lit period.
    task automatic run_session(input int n);
        int base;
        base = runs_done;
        plan_session(n);
        @(negedge clk);
        en = 1'b1;
        wait_runs(base + n - 1);
        repeat ($urandom_range(0, 100)) @(negedge clk);
        en = 1'b0;
        finish_session();
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int fd0;
        int base;
        int k;
        rst = 1'b0;
        en  = 1'b0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < COLS; c++)
                for (int ch = 0; ch < 3; ch++)
                    pix[r][c][ch] = BITS'($urandom_range(0, (1 << BITS) - 1));

        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_oe_n", int'(bus.oe_n), 1);
        check("rst_lat", int'(bus.LAT), 0);
        check("rst_sclk", int'(bus.SCLK), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fb_rd_en", int'(bus.fb_rd_en), 0);
        check("rst_row_addr", int'({bus.D, bus.C, bus.B, bus.A}), 0);
        check("rst_frame_done", int'(frame_done), 0);

        // Two whole frames and a little more, continuously.
        fd0 = fd_cnt;
        run_session(130);
        check("frame_done_count", fd_cnt - fd0, 2);

        // Stop during row 5, plane 2.
        run_session(5 * BITS + 2 + 1);

        // Short random session.
        run_session($urandom_range(2, 12));

        // Reset in the middle of a lit period.
        base = runs_done;
        plan_session(16);
        @(negedge clk);
        en = 1'b1;
        wait_runs(base + $urandom_range(1, 3));
        k = 0;
        while (bus.oe_n && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (bus.oe_n) fail_now("wait_lit_timeout");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_oe_n", int'(bus.oe_n), 1);
        check("async_rst_lat", int'(bus.LAT), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_sclk", int'(bus.SCLK), 0);
        check("async_rst_fb_rd_en", int'(bus.fb_rd_en), 0);
        exp_rd_q.delete();
        exp_bit_q.delete();
        exp_lat_q.delete();
        exp_run_q.delete();
        repeat (2) @(negedge clk);
        base = runs_done;
        plan_session(3);
        rst = 1'b1;
        wait_runs(base + 2);
        repeat ($urandom_range(0, 100)) @(negedge clk);
        en = 1'b0;
        finish_session();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Scan controller for the 64x32 HUB75 LED panel (1/16 scan, two half-panels driven in parallel).
- Sequences the full panel datapath: frame-buffer reads, column shifting, latching, row addressing, and binary-coded-modulation (BCM) output-enable timing.
- One frame covers 16 rows x BITS bit planes.
- Sits between the frame-buffer RAM (fixed 1-cycle read latency) and the panel connector pins.

Parameters:
- BITS, 4, colour depth per channel (bit planes); legal range 1..8.
- BASE_TIME, 8, oe_n-low cycles for plane 0; plane p is lit for BASE_TIME<<p cycles.
- COLS, 64, columns shifted per row-plane.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  run enable.
- fb_rd_en  out  1  frame-buffer read strobe; data returns exactly 1 cycle later.
- fb_addr  out  10  {row[3:0], col[5:0]}.
- fb_rdata  in  6*BITS  {R0,G0,B0,R1,G1,B1}, each BITS wide; R0/G0/B0 = upper half row, R1/G1/B1 = row+16.
- A, B, C, D  out  1 each  row address; {D,C,B,A} = row.
- R0, G0, B0, R1, G1, B1  out  1 each  serial colour data.
- SCLK  out  1  panel shift clock.
- LAT  out  1  latch strobe, active high.
- oe_n  out  1  output enable, active low (1 = blank).
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at frame end.

Behaviour:
- All outputs are registered.
- Reset values: oe_n=1; every other output 0; row=0, plane=0; state IDLE.
- States and transitions:
  - IDLE -> SHIFT on the first cycle en=1 is sampled.
  - SHIFT: 2*COLS+2 cycles (130 at default); then BLANK.
  - BLANK: 1 cycle, then LATCH.
  - LATCH: 1 cycle, then DISPLAY.
  - DISPLAY: BASE_TIME<<plane cycles, then the next row-plane.
- SHIFT timing (t = cycle index within SHIFT, c = column 0..COLS-1):
  - fb_rd_en=1 and fb_addr={row,c} at t=2c; fb_rd_en=0 on all other cycles.
  - fb_rdata is sampled at t=2c+1.
  - Colour outputs hold component[plane] of that word during t=2c+2 and 2c+3.
  - SCLK=0 at t=2c+2 and SCLK=1 at t=2c+3 (64 rising edges per row-plane).
  - oe_n=1 and LAT=0 throughout.
- BLANK: oe_n=1, SCLK=0, {D,C,B,A} updated to the row just shifted.
- LATCH: LAT=1 for exactly 1 cycle, oe_n=1.
- DISPLAY: oe_n=0, LAT=0, row address and colour outputs held.
- Sequencing:
  - Plane increments 0..BITS-1 within a row.
  - At plane wrap, plane returns to 0 and row increments; row wraps 15 -> 0.
- Frame end (DISPLAY of row 15, plane BITS-1 completes): frame_done=1 for that cycle only (the cycle after the last oe_n=0 cycle).
- en deassertion: en is sampled only at the end of each DISPLAY. If en=0, the block returns to IDLE with row=plane=0 and oe_n=1. A row-plane is never truncated.
- Reset mid-operation: immediate return to reset values. No partial LAT pulse follows reset release.
- Width rules:
  - Display timer wide enough for BASE_TIME<<(BITS-1); no overflow at BITS=8.
  - Column counter covers 0..COLS.
- Cycle counts at defaults:
  - Per row-plane: 132 + 8<<p.
  - Per row: 648 cycles.
  - Full frame: 10368 cycles, plus 1 IDLE exit cycle on the first start.

Test Plan:
- Reset with en=0 -> oe_n=1, LAT=SCLK=busy=fb_rd_en=0, {D,C,B,A}=0, state held indefinitely.
- en=1, frame buffer returns fb_rdata = address-derived pattern (R0 = col[0] per plane) -> exactly 64 fb_rd_en pulses with fb_addr 0..63 per row-plane. On every SCLK rise, R0 equals the expected bit for that column and plane. Exactly one LAT pulse per row-plane.
- BITS=4, BASE_TIME=8 -> oe_n-low runs of 8, 16, 32, 64 cycles per row. LAT occurs only while oe_n=1. Row address is stable throughout DISPLAY and changes only in BLANK.
- Continuous run -> frame_done pulses exactly 10368 cycles apart. {D,C,B,A} sequence 0..15 then wraps to 0. Row 16+r data appears on R1/G1/B1.
- Drop en mid-SHIFT of row 5, plane 2 -> that row-plane completes its full DISPLAY (32 cycles), then IDLE with busy=0 and oe_n=1. Re-asserting en restarts at fb_addr {row 0, col 0}.
- Assert rst (low) during DISPLAY -> oe_n=1 and LAT=0 immediately. After release with en=1, the scan restarts at row 0, plane 0 with a full 130-cycle SHIFT.
